// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache read-port slice.
//   CACHE_WIDTH  - data width of one cache entry
//   CACHE_DEPTH  - number of cache entries
//   CACHE_ADDR_W - address width, clog2(CACHE_DEPTH)
//   rd_state_t   - occupancy of the read port's output stage plus skid buffer
package cache_pkg;

  localparam int CACHE_WIDTH  = 16;
  localparam int CACHE_DEPTH  = 8;
  localparam int CACHE_ADDR_W = 3;

  // RD_EMPTY: nothing held; RD_ONE: output stage full;
  // RD_TWO: output stage and skid buffer both full
  typedef enum logic [1:0] {
    RD_EMPTY,
    RD_ONE,
    RD_TWO
  } rd_state_t;

endpackage

// File: rtl/cache_entry_16.sv
// cache_entry_16: one WIDTH-bit storage element of the cache bank.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset, clears the entry to 0
//   en   - load enable; q takes d at the next edge when high
//   d    - write data
//   q    - stored value
module cache_entry_16
  import cache_pkg::*;
#(
  parameter int WIDTH = CACHE_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_read_port_16.sv
// cache_read_port_16: bank of DEPTH cache entries with a write port and a
// valid/ready read port. Responses are registered, and a one-entry skid
// buffer absorbs a request accepted while the output is stalled.
// Ports:
//   CLK, RST           - clock and synchronous active-high reset
//   storage_activator  - write enable for entry wr_addr
//   wr_addr, wr_data   - write address and data
//   rd_req_valid       - read request present
//   rd_req_ready       - port can accept a request (depends on state only)
//   rd_addr            - read address, sampled on acceptance
//   rd_resp_valid      - response available
//   rd_resp_ready      - consumer takes the response this cycle
//   rd_resp_data       - read data, held stable until consumed
//   rd_resp_addr       - address that produced rd_resp_data
module cache_read_port_16
  import cache_pkg::*;
#(
  parameter int WIDTH  = CACHE_WIDTH,
  parameter int DEPTH  = CACHE_DEPTH,
  parameter int ADDR_W = CACHE_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              storage_activator,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [WIDTH-1:0]  rd_resp_data,
  output logic [ADDR_W-1:0] rd_resp_addr
);

  logic [WIDTH-1:0] entry_q [DEPTH];

  rd_state_t state, state_next;

  logic [WIDTH-1:0]  skid_data;
  logic [ADDR_W-1:0] skid_addr;
  logic [WIDTH-1:0]  fetch_data;

  logic accept;
  logic consume;
  logic load_out_fetch;
  logic load_out_skid;
  logic load_skid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    cache_entry_16 #(
      .WIDTH(WIDTH)
    ) u_entry (
      .CLK(CLK),
      .RST(RST),
      .en (storage_activator && (wr_addr == ADDR_W'(i))),
      .d  (wr_data),
      .q  (entry_q[i])
    );
  end

  // Write-first bypass: a same-address write on the accepting edge wins,
  // since the entry register only takes wr_data at that very edge.
  assign fetch_data = (storage_activator && (wr_addr == rd_addr)) ? wr_data
                                                                   : entry_q[rd_addr];

  assign rd_req_ready  = (state != RD_TWO);
  assign rd_resp_valid = (state != RD_EMPTY);
  assign accept        = rd_req_valid && rd_req_ready;
  assign consume       = rd_resp_valid && rd_resp_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RD_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_out_fetch = 1'b0;
    load_out_skid  = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      RD_EMPTY: begin
        if (accept) begin
          load_out_fetch = 1'b1;
          state_next     = RD_ONE;
        end
      end
      RD_ONE: begin
        if (accept && consume) begin
          load_out_fetch = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = RD_TWO;
        end else if (consume) begin
          state_next = RD_EMPTY;
        end
      end
      RD_TWO: begin
        if (consume) begin
          load_out_skid = 1'b1;
          state_next    = RD_ONE;
        end
      end
      default: state_next = RD_EMPTY;
    endcase
  end

  // Data is snapshotted into these registers at acceptance, so later writes
  // to the source entry cannot disturb a response already in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_resp_data <= '0;
      rd_resp_addr <= '0;
      skid_data    <= '0;
      skid_addr    <= '0;
    end else begin
      if (load_out_fetch) begin
        rd_resp_data <= fetch_data;
        rd_resp_addr <= rd_addr;
      end else if (load_out_skid) begin
        rd_resp_data <= skid_data;
        rd_resp_addr <= skid_addr;
      end
      if (load_skid) begin
        skid_data <= fetch_data;
        skid_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_cache_read_port_16.sv
// tb_cache_read_port_16: directed, table-driven bench for cache_read_port_16.
// Each vector is applied for one cycle; the expected outputs are those seen
// while the vector's inputs are present, i.e. before the edge that samples them.
module tb_cache_read_port_16;

  logic        CLK;
  logic        RST;
  logic        storage_activator;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rd_addr;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [15:0] rd_resp_data;
  logic [2:0]  rd_resp_addr;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rv;
    logic [2:0]  ra;
    logic        rr;
    logic        expRdy;
    logic        expVld;
    logic        chkData;
    logic [15:0] expData;
    logic [2:0]  expAddr;
  } vec_t;

  vec_t vecs[$];

  cache_read_port_16 dut (
    .CLK              (CLK),
    .RST              (RST),
    .storage_activator(storage_activator),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .rd_addr          (rd_addr),
    .rd_resp_valid    (rd_resp_valid),
    .rd_resp_ready    (rd_resp_ready),
    .rd_resp_data     (rd_resp_data),
    .rd_resp_addr     (rd_resp_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(logic rst, logic we, logic [2:0] wa, logic [15:0] wd,
                              logic rv, logic [2:0] ra, logic rr,
                              logic expRdy, logic expVld, logic chkData,
                              logic [15:0] expData, logic [2:0] expAddr);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra; v.rr = rr;
    v.expRdy = expRdy; v.expVld = expVld; v.chkData = chkData;
    v.expData = expData; v.expAddr = expAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge, check at the falling edge,
  // then advance past the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    RST               = v.rst;
    storage_activator = v.we;
    wr_addr           = v.wa;
    wr_data           = v.wd;
    rd_req_valid      = v.rv;
    rd_addr           = v.ra;
    rd_resp_ready     = v.rr;
    @(negedge CLK);
    checkOutput($sformatf("vec%0d rd_req_ready", idx), {15'd0, rd_req_ready}, {15'd0, v.expRdy});
    checkOutput($sformatf("vec%0d rd_resp_valid", idx), {15'd0, rd_resp_valid}, {15'd0, v.expVld});
    if (v.chkData) begin
      checkOutput($sformatf("vec%0d rd_resp_data", idx), rd_resp_data, v.expData);
      checkOutput($sformatf("vec%0d rd_resp_addr", idx), {13'd0, rd_resp_addr}, {13'd0, v.expAddr});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; storage_activator = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_resp_ready = 1'b0;

    // rst we wa wd       rv ra rr | rdy vld chk data     addr
    // reset contents: back-to-back reads of 0..7, one response per cycle
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 0, 16'h0000, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 3'(i), 1, 1, 1, 1, 16'h0000, 3'(i - 1)));
    // write 0xBEEF to 3, then read it
    vecs.push_back(mk(0, 1, 3, 16'hBEEF, 0, 0, 1, 1, 1, 1, 16'h0000, 7));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 3, 1, 1, 0, 0, 16'h0000, 0));
    // collision: write 0x1234 to 5 while accepting a read of 5
    vecs.push_back(mk(0, 1, 5, 16'h1234, 1, 5, 1, 1, 1, 1, 16'hBEEF, 3));
    vecs.push_back(mk(0, 1, 1, 16'h0011, 0, 0, 1, 1, 1, 1, 16'h1234, 5));
    vecs.push_back(mk(0, 1, 2, 16'h0022, 0, 0, 1, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 4, 16'h00AA, 0, 0, 1, 1, 0, 0, 16'h0000, 0));
    // back-pressure: two accepts fill output+skid, third request refused
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 0, 1, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 0, 0, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 0, 0, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h0022, 2));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 16'h0000, 0));
    // snapshot: stalled read of 4, then overwrite 4
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 4, 16'h5555, 0, 0, 0, 1, 1, 1, 16'h00AA, 4));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h00AA, 4));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h00AA, 4));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 1, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h5555, 4));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 0));
    // mid-operation reset from the full state
    vecs.push_back(mk(0, 1, 6, 16'h6666, 0, 0, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 0, 1, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h0011, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 16'h0000, 0));

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset rd_req_ready", {15'd0, rd_req_ready}, 16'd1);
    checkOutput("reset rd_resp_valid", {15'd0, rd_resp_valid}, 16'd0);
    checkOutput("reset rd_resp_data", rd_resp_data, 16'h0000);
    checkOutput("reset rd_resp_addr", {13'd0, rd_resp_addr}, 16'd0);
    @(posedge CLK);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // After the mid-operation reset every entry, including the one written
    // just before it, must read back as zero.
    for (int a = 0; a < 8; a++) begin
      int waitCycles;
      storage_activator = 1'b0;
      rd_req_valid      = 1'b1;
      rd_addr           = 3'(a);
      rd_resp_ready     = 1'b1;
      @(negedge CLK);
      checkOutput($sformatf("sweep%0d rd_req_ready", a), {15'd0, rd_req_ready}, 16'd1);
      @(posedge CLK);
      #1;
      rd_req_valid = 1'b0;
      waitCycles   = 0;
      @(negedge CLK);
      while (!rd_resp_valid && waitCycles < 4) begin
        @(negedge CLK);
        waitCycles++;
      end
      if (!rd_resp_valid) begin
        checkOutput($sformatf("sweep%0d response timeout", a), 16'd0, 16'd1);
      end else begin
        checkOutput($sformatf("sweep%0d rd_resp_data", a), rd_resp_data, 16'h0000);
        checkOutput($sformatf("sweep%0d rd_resp_addr", a), {13'd0, rd_resp_addr}, 16'(a));
      end
      @(posedge CLK);
      #1;
    end

    @(negedge CLK);
    checkOutput("final rd_resp_valid", {15'd0, rd_resp_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
